// File: rtl/twobit_comparator_bist.sv
// twobit_comparator_bist: BIST sweeping 16 patterns onto a 2-bit comparator (OutA..OutD drive X,Y; InF1..3 are >,==,<) and reporting busy/done/pass/err_count/first_fail
module twobit_comparator_bist #(
  parameter int SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       OutA,
  output logic       OutB,
  output logic       OutC,
  output logic       OutD,
  input  logic       InF1,
  input  logic       InF2,
  input  logic       InF3,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] err_count,
  output logic [3:0] first_fail,
  output logic       first_fail_valid
);
  typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, DONE} state_t;
  state_t r_state, w_next;
  logic [3:0] r_p, r_cnt, r_ff;
  logic [4:0] r_err, w_err_next;
  logic r_pass, r_ffv;
  logic [1:0] w_x, w_y;
  logic [2:0] w_exp;
  logic w_mis, w_settled;
  assign w_x = r_p[3:2];
  assign w_y = r_p[1:0];
  assign w_exp = {w_x > w_y, w_x == w_y, w_x < w_y};
  assign w_mis = {InF1, InF2, InF3} != w_exp;
  assign w_err_next = r_err + 5'(w_mis);
  assign w_settled = r_cnt == 4'(SETTLE - 1);
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    w_next = start ? APPLY : IDLE;
      APPLY:   w_next = w_settled ? SAMPLE : APPLY;
      SAMPLE:  w_next = (r_p == 4'd15) ? DONE : APPLY;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) r_state <= rst ? IDLE : w_next;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_p   <= '0;
      r_cnt <= '0;
      r_err <= '0;
      r_pass <= 1'b0;
      r_ff  <= '0;
      r_ffv <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: if (start) begin
          r_p   <= '0;
          r_cnt <= '0;
          r_err <= '0;
          r_pass <= 1'b0;
          r_ff  <= '0;
          r_ffv <= 1'b0;
        end
        APPLY: r_cnt <= w_settled ? 4'd0 : r_cnt + 4'd1;
        SAMPLE: begin
          r_err <= w_err_next;
          if (w_mis && !r_ffv) begin
            r_ff  <= r_p;
            r_ffv <= 1'b1;
          end
          if (r_p == 4'd15) r_pass <= w_err_next == 5'd0;
          else r_p <= r_p + 4'd1;
        end
        default: ;
      endcase
    end
  end
  assign busy = (r_state == APPLY) || (r_state == SAMPLE);
  assign done = r_state == DONE;
  assign {OutA, OutB, OutC, OutD} = busy ? r_p : 4'd0;
  assign pass = r_pass;
  assign err_count = r_err;
  assign first_fail = r_ff;
  assign first_fail_valid = r_ffv;
endmodule

// File: tb/tb_twobit_comparator_bist.sv
// tb_twobit_comparator_bist: randomized self-checking bench with cycle-level reference model
module tb_twobit_comparator_bist;
  localparam int S = 2;
  localparam int N = 16 * (S + 1);
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic st[3];
  logic [3:0] o0, o1, o2;
  logic [2:0] f0, f1, f2;
  logic bz[3], dn[3], ps[3], fv[3];
  logic [4:0] ec[3];
  logic [3:0] ffo[3];
  logic [2:0] mask[16];
  int mode = 0;
  int tests = 0, fails = 0;
  int k = -1, m_err = 0, m_ff = 0, m_ffv = 0, m_pass = 0, mp;
  bit armed = 0;
  always #5 clk = ~clk;
  function automatic logic [2:0] cmp(int md, logic [3:0] p, logic [2:0] m);
    int x, y;
    logic [2:0] g;
    x = int'(p[3:2]);
    y = int'(p[1:0]);
    g = {x > y, x == y, x < y};
    return md == 1 ? (g & 3'b101) : md == 2 ? {g[0], g[1], g[2]} : md == 3 ? (g ^ m) : g;
  endfunction
  always_comb f0 = cmp(mode, o0, mask[o0]);
  always_comb f1 = cmp(0, o1, 3'b0);
  always_comb f2 = cmp(0, o2, 3'b0);
  twobit_comparator_bist #(.SETTLE(2)) u0 (
    .clk(clk), .rst(rst), .start(st[0]),
    .OutA(o0[3]), .OutB(o0[2]), .OutC(o0[1]), .OutD(o0[0]),
    .InF1(f0[2]), .InF2(f0[1]), .InF3(f0[0]),
    .busy(bz[0]), .done(dn[0]), .pass(ps[0]), .err_count(ec[0]),
    .first_fail(ffo[0]), .first_fail_valid(fv[0]));
  twobit_comparator_bist #(.SETTLE(1)) u1 (
    .clk(clk), .rst(rst), .start(st[1]),
    .OutA(o1[3]), .OutB(o1[2]), .OutC(o1[1]), .OutD(o1[0]),
    .InF1(f1[2]), .InF2(f1[1]), .InF3(f1[0]),
    .busy(bz[1]), .done(dn[1]), .pass(ps[1]), .err_count(ec[1]),
    .first_fail(ffo[1]), .first_fail_valid(fv[1]));
  twobit_comparator_bist #(.SETTLE(15)) u2 (
    .clk(clk), .rst(rst), .start(st[2]),
    .OutA(o2[3]), .OutB(o2[2]), .OutC(o2[1]), .OutD(o2[0]),
    .InF1(f2[2]), .InF2(f2[1]), .InF3(f2[0]),
    .busy(bz[2]), .done(dn[2]), .pass(ps[2]), .err_count(ec[2]),
    .first_fail(ffo[2]), .first_fail_valid(fv[2]));
  task automatic chk(input string n, input int a, input int e);
    tests++;
    if (a != e) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
    end
  endtask
  // k is the index of the cycle within the sweep: 0..N-1 busy, N is the done cycle, -1 idle
  always @(posedge clk) begin
    if (rst) begin
      k = -1; m_err = 0; m_ff = 0; m_ffv = 0; m_pass = 0; armed = 1;
    end else if (k < 0) begin
      if (st[0]) begin
        k = 0; m_err = 0; m_ff = 0; m_ffv = 0; m_pass = 0;
      end
    end else if (k < N) begin
      if (k % (S + 1) == S) begin
        mp = k / (S + 1);
        if (cmp(mode, 4'(mp), mask[mp]) != cmp(0, 4'(mp), 3'b0)) begin
          m_err++;
          if (m_ffv == 0) begin
            m_ff = mp; m_ffv = 1;
          end
        end
      end
      k++;
      if (k == N) m_pass = (m_err == 0);
    end else k = -1;
  end
  always @(negedge clk) if (armed) begin
    chk("busy", bz[0], int'(k >= 0 && k < N));
    chk("done", dn[0], int'(k == N));
    chk("pattern", o0, (k >= 0 && k < N) ? k / (S + 1) : 0);
    chk("err_count", ec[0], m_err);
    chk("first_fail", ffo[0], m_ff);
    chk("first_fail_valid", fv[0], m_ffv);
    chk("pass", ps[0], m_pass);
  end
  task automatic wait_done(input int i, input int lim, input bit noise, inout int lat);
    while (!dn[i] && lat < lim) begin
      if (noise) st[i] = 1'($urandom % 2);
      @(posedge clk); #1;
      lat++;
    end
    st[i] = 1'b0;
    chk("done_seen", dn[i], 1);
  endtask
  task automatic go(input int i, input int lim, input bit noise, output int lat);
    st[i] = 1'b1;
    @(posedge clk); #1;
    st[i] = 1'b0;
    lat = 1;
    wait_done(i, lim, noise, lat);
  endtask
  initial begin
    int lat, cnt, e_err, e_ff;
    for (int i = 0; i < 3; i++) st[i] = 1'b0;
    for (int i = 0; i < 16; i++) mask[i] = 3'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_busy", bz[0], 0);
    chk("reset_err", ec[0], 0);
    repeat (6) @(posedge clk);
    #1;
    go(0, 200, 0, lat);
    chk("golden_latency", lat, 49);
    chk("golden_err", ec[0], 0);
    chk("golden_pass", ps[0], 1);
    chk("golden_ffv", fv[0], 0);
    @(posedge clk); #1;
    mode = 1;
    go(0, 200, 0, lat);
    chk("f2stuck_err", ec[0], 4);
    chk("f2stuck_ff", ffo[0], 0);
    chk("f2stuck_pass", ps[0], 0);
    @(posedge clk); #1;
    mode = 2;
    go(0, 200, 0, lat);
    chk("swap_err", ec[0], 12);
    chk("swap_ff", ffo[0], 1);
    chk("swap_pass", ps[0], 0);
    @(posedge clk); #1;
    mode = 0;
    st[0] = 1'b1;
    @(posedge clk); #1;
    st[0] = 1'b0;
    repeat (19) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", bz[0], 0);
    chk("abort_pattern", o0, 0);
    chk("abort_pass", ps[0], 0);
    cnt = 0;
    repeat (60) begin
      @(posedge clk); #1;
      cnt += int'(dn[0]);
    end
    chk("abort_no_done", cnt, 0);
    go(0, 200, 0, lat);
    chk("after_abort_latency", lat, 49);
    chk("after_abort_pass", ps[0], 1);
    @(posedge clk); #1;
    mode = 1;
    go(0, 200, 1, lat);
    chk("noise_latency", lat, 49);
    chk("noise_err", ec[0], 4);
    st[0] = 1'b1;
    @(posedge clk); #1;
    chk("start_in_done_ignored", bz[0], 0);
    chk("hold_err", ec[0], 4);
    mode = 0;
    @(posedge clk); #1;
    st[0] = 1'b0;
    chk("restart_busy", bz[0], 1);
    chk("restart_cleared", ec[0], 0);
    lat = 1;
    wait_done(0, 200, 0, lat);
    chk("restart_latency", lat, 49);
    chk("restart_pass", ps[0], 1);
    repeat (4) begin
      @(posedge clk); #1;
      e_err = 0;
      e_ff = -1;
      for (int i = 0; i < 16; i++) begin
        mask[i] = ($urandom % 2 == 0) ? 3'b0 : 3'($urandom_range(1, 7));
        if (mask[i] != 3'b0) begin
          e_err++;
          if (e_ff < 0) e_ff = i;
        end
      end
      mode = 3;
      go(0, 200, 1, lat);
      chk("rand_latency", lat, 49);
      chk("rand_err", ec[0], e_err);
      chk("rand_ffv", fv[0], int'(e_ff >= 0));
      if (e_ff >= 0) chk("rand_ff", ffo[0], e_ff);
      chk("rand_pass", ps[0], int'(e_err == 0));
    end
    @(posedge clk); #1;
    go(1, 100, 0, lat);
    chk("settle1_latency", lat, 33);
    chk("settle1_pass", ps[1], 1);
    chk("settle1_err", ec[1], 0);
    go(2, 400, 0, lat);
    chk("settle15_latency", lat, 257);
    chk("settle15_pass", ps[2], 1);
    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
